bus_output_display: RTL and testbench
=====================================

Name: bus_output_display

Overview:
- Output stage of the 8-bit CPU, directly downstream of the shared bus. It is the consumer of the control unit's out_en.
- On a load strobe it captures the bus byte into the output register.
- It then converts the byte to decimal with a sequential double-dabble, in unsigned or two's-complement form.
- It drives a multiplexed 4-digit 7-segment display with leading-zero blanking and a fixed sign digit.

Parameters:
- REFRESH_DIV, 6750: clk cycles each digit is held before the mux advances (27 MHz / 6750 = 4 kHz digit rate).
- COMMON_ANODE, 1: 1 inverts both segments and digit at the pins (active-low drive); 0 drives them active-high.

Ports:
- clk  input  1  system clock, the only clock.
- rst  input  1  synchronous reset, active-high.
- load  input  1  single-cycle capture strobe (out_en qualified), synchronous to clk.
- bus  input  8  CPU bus value.
- signed_mode  input  1  1 selects two's-complement display; sampled only when load=1.
- value  output  8  output register contents, for LEDs.
- busy  output  1  conversion in progress.
- segments  output  8  {dp,g,f,e,d,c,b,a} for the currently selected digit.
- digit  output  4  one-hot digit select; bit0 is the rightmost digit.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high, ports named clk and rst.
  - All state updates on the rising edge of clk.
  - On rst:
    - value=0, busy=0, FSM=IDLE, refresh counter=0, digit index=0.
    - Digit registers show "   0": ones=0, tens/hundreds/sign blank.
  - rst has priority over load. Asserting rst mid-conversion aborts it; the next cycle shows reset outputs.
- Capture:
  - load=1 on edge E0 sets value<=bus and latches signed_mode into the sign-mode register.
  - The FSM enters SHIFT with iteration count 0, and busy=1 from E0.
  - load while busy is accepted: value is recaptured and the conversion restarts from iteration 0. The aborted result is never displayed.
- Magnitude:
  - If sign mode is set and bit7=1: sign=1 and magnitude=(~value+1) as unsigned 8-bit, so 0x80 gives 128.
  - Otherwise sign=0 and magnitude=value.
- FSM states: IDLE, SHIFT, LATCH.
  - SHIFT, edges E1..E8: one double-dabble iteration per cycle on a 12-bit BCD accumulator. Add 3 to any nibble >=5, then shift in the magnitude MSB-first.
  - After the 8th iteration the FSM moves to LATCH.
  - LATCH, edge E9: digit registers update atomically, busy<=0, FSM to IDLE.
  - Load-to-display latency is 9 cycles. The displayed digits stay unchanged while busy.
- Blanking:
  - Hundreds is blank if 0.
  - Tens is blank if hundreds=0 and tens=0.
  - Ones is always shown.
  - Digit 3 shows minus (0x40) if sign=1, otherwise blank.
- Segment codes (active-high, before the COMMON_ANODE inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - minus=40, blank=00. dp is always 0.
- Multiplex:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, the digit index advances 0->1->2->3->0.
  - digit is the one-hot of the index. segments is combinational from the selected digit register, so it switches in the same cycle as digit.
  - The mux runs independently of the FSM and of load.
- signed_mode changes without a load have no effect.

Test Plan:
1. Reset, COMMON_ANODE=0, REFRESH_DIV=4 -> busy=0 and value=0x00. Index 0: digit=0001, segments=0x3F. Indices 1..3: segments=0x00.
2. load with bus=0xFF, signed_mode=0 -> busy high for exactly 9 cycles; value=0xFF. Digits 3..0 become blank, 0x5B, 0x6D, 0x6D ("255").
3. Signed, bus=0xFF -> digits: 0x40, blank, blank, 0x06 ("-  1"). Signed, bus=0x80 -> 0x40, 0x06, 0x5B, 0x7F ("-128").
4. load 0x07, then load 0x2A three cycles later -> busy stays high until 9 cycles after the second load. Display changes once to "  42" (0x66, 0x5B); 0x07 never appears.
5. REFRESH_DIV=4:
   - COMMON_ANODE=0 -> digit sequence 0001, 0010, 0100, 1000, each held 4 cycles, then repeats.
   - COMMON_ANODE=1 -> digit=1110 first and segments bitwise inverted.
6. rst asserted at iteration 4 of converting 0x63 -> next cycle busy=0 and value=0, display "   0". The 99 result never appears.

Source files
------------

// File: rtl/bus_output_display_if.sv
// Bus-side capture and display pins of the CPU output stage.
// master drives the load strobe and bus byte; slave is the display block.
interface bus_output_display_if;
    logic       load;
    logic [7:0] bus;
    logic       signed_mode;
    logic [7:0] value;
    logic       busy;
    logic [7:0] segments;
    logic [3:0] digit;

    modport master (
        output load, bus, signed_mode,
        input  value, busy, segments, digit
    );

    modport slave (
        input  load, bus, signed_mode,
        output value, busy, segments, digit
    );
endinterface

// File: rtl/bus_output_display.sv
// Captures the bus byte, converts it to decimal by double-dabble and drives a 4-digit mux display.
// Latency: 9 cycles load-to-display. No backpressure: load is always taken and restarts a conversion.
module bus_output_display #(
    parameter int REFRESH_DIV  = 6750,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_output_display_if.slave  io
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [7:0]        value_q;
    logic              sign_mode_q;
    logic [2:0]        iter_q;
    logic [11:0]       bcd_q;
    logic [3:0][7:0]   disp_q;
    logic [CW-1:0]     refresh_q;
    logic [1:0]        idx_q;

    logic              neg;
    logic [7:0]        mag;
    logic [11:0]       bcd_adj;
    logic [11:0]       bcd_nxt;
    logic [3:0][7:0]   disp_nxt;
    logic              busy;
    logic              shift_en;
    logic              latch_en;
    logic [7:0]        sel_seg;
    logic [3:0]        sel_onehot;

    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // value_q and sign_mode_q stay frozen for the whole conversion, so this is stable.
    always_comb begin
        neg = sign_mode_q & value_q[7];
        mag = neg ? (~value_q + 8'd1) : value_q;
    end

    always_comb begin
        bcd_adj = {dd_adj(bcd_q[11:8]), dd_adj(bcd_q[7:4]), dd_adj(bcd_q[3:0])};
        bcd_nxt = {bcd_adj[10:0], mag[3'd7 - iter_q]};
    end

    always_comb begin
        disp_nxt[0] = seg7(bcd_q[3:0]);
        disp_nxt[1] = ((bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0)) ? 8'h00 : seg7(bcd_q[7:4]);
        disp_nxt[2] = (bcd_q[11:8] == 4'd0) ? 8'h00 : seg7(bcd_q[11:8]);
        disp_nxt[3] = neg ? 8'h40 : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (io.load) begin
            state_nxt = SHIFT;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                SHIFT:   state_nxt = (iter_q == 3'd7) ? LATCH : SHIFT;
                LATCH:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A load in any state wins over the pending shift or latch, so an aborted result never lands.
    always_comb begin
        busy     = (state != IDLE);
        shift_en = (state == SHIFT) && !io.load;
        latch_en = (state == LATCH) && !io.load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q     <= 8'h00;
            sign_mode_q <= 1'b0;
            iter_q      <= 3'd0;
            bcd_q       <= 12'h000;
            disp_q      <= {8'h00, 8'h00, 8'h00, 8'h3F};
        end else begin
            if (io.load) begin
                value_q     <= io.bus;
                sign_mode_q <= io.signed_mode;
                iter_q      <= 3'd0;
                bcd_q       <= 12'h000;
            end else if (shift_en) begin
                bcd_q  <= bcd_nxt;
                iter_q <= iter_q + 3'd1;
            end
            if (latch_en) begin
                disp_q <= disp_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            idx_q     <= 2'd0;
        end else if (refresh_q == CW'(REFRESH_DIV - 1)) begin
            refresh_q <= '0;
            idx_q     <= idx_q + 2'd1;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    always_comb begin
        sel_seg    = disp_q[idx_q];
        sel_onehot = 4'b0001 << idx_q;
    end

    assign io.value    = value_q;
    assign io.busy     = busy;
    assign io.segments = COMMON_ANODE ? ~sel_seg : sel_seg;
    assign io.digit    = COMMON_ANODE ? ~sel_onehot : sel_onehot;

endmodule

// File: tb/tb_bus_output_display.sv
// Scoreboard bench: two DUTs (active-high and common-anode) share stimulus; a monitor checks
// every cycle's muxed digit against a reference display and pops results as busy falls.
module tb_bus_output_display;

    logic clk;
    logic rst;

    bus_output_display_if a ();
    bus_output_display_if b ();

    assign b.load        = a.load;
    assign b.bus         = a.bus;
    assign b.signed_mode = a.signed_mode;

    bus_output_display #(.REFRESH_DIV(4), .COMMON_ANODE(1'b0)) dut0 (.clk(clk), .rst(rst), .io(a.slave));
    bus_output_display #(.REFRESH_DIV(4), .COMMON_ANODE(1'b1)) dut1 (.clk(clk), .rst(rst), .io(b.slave));

    typedef struct packed {
        logic [7:0]      value;
        logic [3:0][7:0] seg;
        logic [7:0]      cycles;
    } exp_t;

    exp_t            q[$];
    exp_t            e;
    logic [3:0][7:0] exp_disp;
    int              n_cmp = 0;
    int              n_err = 0;
    int              busy_cnt = 0;
    logic            prev_busy = 1'b0;
    logic            armed = 1'b0;
    logic            rst_seen;
    logic [1:0]      mcnt;
    logic [1:0]      midx;
    logic [7:0]      inv_seg;
    logic [3:0]      exp_dig;
    logic [3:0]      inv_dig;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation ran past time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, want);
        end
    endtask

    // Reference digit mux: 4 cycles per digit, cleared by reset.
    always @(posedge clk) begin
        rst_seen <= rst;
        if (rst) begin
            mcnt <= 2'd0;
            midx <= 2'd0;
        end else if (mcnt == 2'd3) begin
            mcnt <= 2'd0;
            midx <= midx + 2'd1;
        end else begin
            mcnt <= mcnt + 2'd1;
        end
    end

    always @(negedge clk) begin
        if (rst_seen === 1'b1) begin
            q.delete();
            exp_disp  = {8'h00, 8'h00, 8'h00, 8'h3F};
            busy_cnt  = 0;
            prev_busy = 1'b0;
            armed     = 1'b1;
            chk("reset_busy", {31'd0, a.busy}, 32'd0);
            chk("reset_value", {24'd0, a.value}, 32'd0);
        end else if (armed) begin
            if (a.busy === 1'b1) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("busy_cycles", busy_cnt, {24'd0, e.cycles});
                    chk("value", {24'd0, a.value}, {24'd0, e.value});
                    exp_disp = e.seg;
                end
                busy_cnt = 0;
            end
            prev_busy = (a.busy === 1'b1);
        end
        if (armed) begin
            exp_dig = 4'b0001 << midx;
            inv_dig = ~exp_dig;
            inv_seg = ~exp_disp[midx];
            chk("digit_ca0", {28'd0, a.digit}, {28'd0, exp_dig});
            chk("segments_ca0", {24'd0, a.segments}, {24'd0, exp_disp[midx]});
            chk("digit_ca1", {28'd0, b.digit}, {28'd0, inv_dig});
            chk("segments_ca1", {24'd0, b.segments}, {24'd0, inv_seg});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_disp(input logic [7:0] v, input logic [7:0] d3, input logic [7:0] d2,
                               input logic [7:0] d1, input logic [7:0] d0, input logic [7:0] cyc);
        exp_t x;
        x.value  = v;
        x.seg    = {d3, d2, d1, d0};
        x.cycles = cyc;
        q.push_back(x);
    endtask

    task automatic load_byte(input logic [7:0] v, input logic sm);
        tick();
        a.load        = 1'b1;
        a.bus         = v;
        a.signed_mode = sm;
        tick();
        a.load        = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        a.load        = 1'b0;
        a.bus         = 8'h00;
        a.signed_mode = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(20);

        expect_disp(8'hFF, 8'h00, 8'h5B, 8'h6D, 8'h6D, 8'd9);
        load_byte(8'hFF, 1'b0);
        tick(30);

        expect_disp(8'hFF, 8'h40, 8'h00, 8'h00, 8'h06, 8'd9);
        load_byte(8'hFF, 1'b1);
        tick(30);
        a.signed_mode = 1'b0;
        tick(10);
        a.signed_mode = 1'b1;
        tick(10);

        expect_disp(8'h80, 8'h40, 8'h06, 8'h5B, 8'h7F, 8'd9);
        load_byte(8'h80, 1'b1);
        tick(30);

        // Second load three cycles after the first: only 42 may ever reach the display.
        expect_disp(8'h2A, 8'h00, 8'h00, 8'h66, 8'h5B, 8'd12);
        tick();
        a.load        = 1'b1;
        a.bus         = 8'h07;
        a.signed_mode = 1'b0;
        tick();
        a.load        = 1'b0;
        tick();
        tick();
        a.load        = 1'b1;
        a.bus         = 8'h2A;
        tick();
        a.load        = 1'b0;
        tick(30);

        expect_disp(8'h64, 8'h00, 8'h06, 8'h3F, 8'h3F, 8'd9);
        load_byte(8'h64, 1'b0);
        tick(30);
        expect_disp(8'h0A, 8'h00, 8'h00, 8'h06, 8'h3F, 8'd9);
        load_byte(8'h0A, 1'b0);
        tick(30);
        expect_disp(8'hF6, 8'h40, 8'h00, 8'h06, 8'h3F, 8'd9);
        load_byte(8'hF6, 1'b1);
        tick(30);
        expect_disp(8'h05, 8'h00, 8'h00, 8'h00, 8'h6D, 8'd9);
        load_byte(8'h05, 1'b1);
        tick(30);
        expect_disp(8'h00, 8'h00, 8'h00, 8'h00, 8'h3F, 8'd9);
        load_byte(8'h00, 1'b0);
        tick(30);

        // Reset lands on the edge of the 4th iteration of converting 99.
        load_byte(8'h63, 1'b0);
        tick(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(30);

        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
